max_unpool: RTL and testbench
=============================

# max_unpool

Inverse of the max-pooling stage: takes one pooled value plus the argmax position it came from and re-expands it into a full pooling window of `WIN` elements. The window holds the value at the argmax slot and zero in every other slot. It sits on the decoder/upsampling side of the datapath and consumes the same signed `DW`-bit sample format the pooling stage produces. Both sides use valid/ready handshakes; output is a serial stream, one window element per beat.

## Interface
Parameters:
- `DW`, `` `DW `` from `global.v`: sample width, signed two's complement.
- `WIN`, 4: elements per pooling window (4 = 2x2, 9 = 3x3); legal range 2..256.
- `IDXW`, `$clog2(WIN)`: argmax index width.

Ports:
- `i_clk`  in  1  clock; all logic on the rising edge.
- `i_rst`  in  1  reset; synchronous, active-high.
- `i_valid`  in  1  input window descriptor valid.
- `o_ready`  out  1  block can accept a descriptor this cycle.
- `i_data`  in  `DW`  signed pooled value.
- `i_idx`  in  `IDXW`  argmax slot within the window, 0..`WIN`-1.
- `o_valid`  out  1  output element valid.
- `i_ready`  in  1  downstream accepts the element.
- `o_data`  out  `DW`  signed element value.
- `o_pos`  out  `IDXW`  slot number of the current element.
- `o_last`  out  1  current element is slot `WIN`-1.
- `o_idx_err`  out  1  sticky flag: a descriptor arrived with `i_idx` >= `WIN`.

## Operation
- States: IDLE (no window held) and EMIT (window being streamed).
- Input handshake: a descriptor is accepted when `i_valid & o_ready` at a clock edge. On acceptance, `i_data` and `i_idx` are latched and `pos` is set to 0. The state goes to (or stays in) EMIT.
- `o_ready` = IDLE | (`o_valid & i_ready & o_last`). This is a combinational path from `i_ready` and permits back-to-back windows with no bubble.
- In EMIT, `o_data` = latched value if `pos` == latched idx, else 0. `o_pos` = `pos`; `o_last` = (`pos` == `WIN`-1).
- Output handshake: a beat completes on `o_valid & i_ready`. Then `pos` increments.
  - If the completed beat is the last beat and no new descriptor is accepted in the same cycle, go to IDLE.
  - If a new descriptor is accepted in that cycle, reload the latch and restart at `pos` 0 in EMIT.
- Backpressure: while `o_valid & !i_ready`, `o_data`, `o_pos` and `o_last` hold stable.
- Out-of-range index (`i_idx` >= `WIN`, possible only when `WIN` is not a power of 2):
  - The full window is still emitted, all zeros.
  - `o_idx_err` is set and stays set until reset.
- The value passes through unmodified. The most negative value (e.g. -32768 for `DW`=16) is preserved with no saturation or sign change.
- Reset has priority over every handshake. A descriptor presented in the reset cycle is dropped.

## Timing
- Reset values: `o_valid`=0, `o_data`=0, `o_pos`=0, `o_last`=0, `o_idx_err`=0, state IDLE. `o_ready`=1 from the first cycle after reset.
- Latency: descriptor accepted at edge N gives first element with `o_valid`=1 after edge N. All outputs except `o_ready` are registered.
- Throughput: one element per cycle with `i_ready`=1. A window takes exactly `WIN` beats. Sustained descriptor rate is one per `WIN` cycles.
- Reset mid-window: the window is discarded. After the reset edge, `o_valid`=0 and the block returns to IDLE; no partial window resumes.
- `o_last` is asserted on exactly one beat per window.

## Structure
- `` `DW `` stays in `global.v`. Add `` `POOL_WIN `` (default 4) to `global.v` so the pooling and unpooling stages share one window-size definition; `WIN` defaults to it.
- State encoding is a local parameter. No package typedefs are needed.
- Single module, no sub-modules. The slot counter is inline.

## Test plan
- Reset: hold `i_rst` 3 cycles with `i_valid`=1 -> all outputs 0 and nothing emitted; `o_ready`=1 after release.
- Single window, `WIN`=4, `DW`=16, value -5, idx 2, `i_ready`=1:
  - Beats: `o_data` 0, 0, -5, 0; `o_pos` 0..3; `o_last` only on beat 4.
  - First beat appears one cycle after acceptance.
- Back-to-back: descriptors (7, idx 0) then (-32768, idx 3) with `i_valid` and `i_ready` held high:
  - 8 consecutive beats: 7, 0, 0, 0, 0, 0, 0, -32768, with no idle cycle.
  - `o_ready` is high on beat 4.
- Backpressure: `i_ready` low for 3 cycles at `o_pos`=1 -> `o_data` and `o_pos` frozen, `o_ready`=0, `o_valid`=1; resumes with `o_pos`=2.
- Bad index, `WIN`=9, `IDXW`=4, value 100, idx 12:
  - 9 zero beats; `o_idx_err`=1 and stays 1 across later valid windows.
  - `o_idx_err` clears only on `i_rst`.
- Reset mid-window: assert `i_rst` at `o_pos`=2 -> next cycle `o_valid`=0 and `o_ready`=1; a new descriptor (3, idx 1) then yields 0, 3, 0, 0.

Source files
------------

// File: rtl/max_unpool_pkg.sv
// Shared definitions for the max-unpooling stage.
// The sample width and pooling window size are project-wide defaults shared
// with the pooling stage; the guards let a project-level definition win.
`ifndef DW
`define DW 16
`endif
`ifndef POOL_WIN
`define POOL_WIN 4
`endif

package max_unpool_pkg;

    // Two-state controller: no window held / window being streamed.
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_EMIT = 1'b1;

endpackage

// File: rtl/max_unpool.sv
// max_unpool: re-expands one pooled value plus its argmax slot into a full
// window of WIN elements, streamed one element per beat. The argmax slot carries
// the value; every other slot carries zero.
//
// Handshake rules (both sides): a transfer happens on a rising edge where
// valid & ready are both high. A valid source holds its payload stable until
// the transfer. o_ready is combinational from i_ready so that a new descriptor
// can be taken on the same edge as the last beat of the current window.
`ifndef DW
`define DW 16
`endif
`ifndef POOL_WIN
`define POOL_WIN 4
`endif

module max_unpool
    import max_unpool_pkg::*;
#(
    parameter int DW   = `DW,
    parameter int WIN  = `POOL_WIN,
    parameter int IDXW = $clog2(WIN)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic signed [DW-1:0]   i_data,
    input  logic [IDXW-1:0]        i_idx,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic signed [DW-1:0]   o_data,
    output logic [IDXW-1:0]        o_pos,
    output logic                   o_last,
    output logic                   o_idx_err
);

    // Slot number of the final element of a window.
    localparam logic [IDXW-1:0] LP_LAST = IDXW'(WIN - 1);
    // Window size widened by one bit so an index can be range-checked.
    localparam logic [IDXW:0]   LP_WIN  = (IDXW + 1)'(WIN);

    logic                 r_state;
    logic                 w_state_nxt;
    logic signed [DW-1:0] r_val;
    logic signed [DW-1:0] r_data;
    logic [IDXW-1:0]      r_idx;
    logic [IDXW-1:0]      r_pos;
    logic                 r_last;
    logic                 r_idx_err;

    logic                 w_valid;
    logic                 w_ready;
    logic                 w_in_fire;
    logic                 w_out_fire;
    logic [IDXW-1:0]      w_pos_inc;
    logic                 w_idx_bad;

    // State register; reset drops any window in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: a new descriptor always (re)starts a window, otherwise the
    // last completed beat returns to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        if (w_in_fire) begin
            w_state_nxt = ST_EMIT;
        end else if (w_out_fire && r_last) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // Handshake outputs decoded from state plus the downstream ready.
    always_comb begin
        w_valid    = (r_state == ST_EMIT);
        w_out_fire = w_valid & i_ready;
        w_ready    = ~w_valid | (w_out_fire & r_last);
        w_in_fire  = i_valid & w_ready;
    end

    // Helper terms for the datapath: next slot and the range check.
    always_comb begin
        w_pos_inc = r_pos + IDXW'(1);
        w_idx_bad = ({1'b0, i_idx} >= LP_WIN);
    end

    // Datapath: latch the descriptor, walk the slot counter and pre-compute the
    // element for the next beat so every stream output comes from a flop.
    // An out-of-range index never matches a slot, so that window is all zeros.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_val     <= '0;
            r_idx     <= '0;
            r_pos     <= '0;
            r_data    <= '0;
            r_last    <= 1'b0;
            r_idx_err <= 1'b0;
        end else begin
            if (w_in_fire && w_idx_bad) begin
                r_idx_err <= 1'b1;
            end
            if (w_in_fire) begin
                r_val  <= i_data;
                r_idx  <= i_idx;
                r_pos  <= '0;
                r_data <= (i_idx == '0) ? i_data : '0;
                r_last <= 1'b0;
            end else if (w_out_fire) begin
                if (r_last) begin
                    r_pos  <= '0;
                    r_data <= '0;
                    r_last <= 1'b0;
                end else begin
                    r_pos  <= w_pos_inc;
                    r_data <= (w_pos_inc == r_idx) ? r_val : '0;
                    r_last <= (w_pos_inc == LP_LAST);
                end
            end
        end
    end

    assign o_ready   = w_ready;
    assign o_valid   = w_valid;
    assign o_data    = r_data;
    assign o_pos     = r_pos;
    assign o_last    = r_last;
    assign o_idx_err = r_idx_err;

endmodule

// File: tb/tb_max_unpool.sv
// Testbench for max_unpool: one instance with a 4-slot window and one with a
// 9-slot window (to reach out-of-range indices). Table vectors, directed
// multi-cycle sequences and a randomized phase against a window-level model.
module tb_max_unpool;

    // ---------------- clock ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT, WIN = 4 ----------------
    logic               rst4, v4, ir4;
    logic signed [15:0] d4;
    logic [1:0]         idx4;
    logic               rdy4, ov4, ol4, oe4;
    logic signed [15:0] od4;
    logic [1:0]         op4;

    max_unpool #(.DW(16), .WIN(4), .IDXW(2)) u_dut4 (
        .i_clk     (clk),
        .i_rst     (rst4),
        .i_valid   (v4),
        .o_ready   (rdy4),
        .i_data    (d4),
        .i_idx     (idx4),
        .o_valid   (ov4),
        .i_ready   (ir4),
        .o_data    (od4),
        .o_pos     (op4),
        .o_last    (ol4),
        .o_idx_err (oe4)
    );

    // ---------------- DUT, WIN = 9 ----------------
    logic               rst9, v9, ir9;
    logic signed [15:0] d9;
    logic [3:0]         idx9;
    logic               rdy9, ov9, ol9, oe9;
    logic signed [15:0] od9;
    logic [3:0]         op9;

    max_unpool #(.DW(16), .WIN(9), .IDXW(4)) u_dut9 (
        .i_clk     (clk),
        .i_rst     (rst9),
        .i_valid   (v9),
        .o_ready   (rdy9),
        .i_data    (d9),
        .i_idx     (idx9),
        .o_valid   (ov9),
        .i_ready   (ir9),
        .o_data    (od9),
        .o_pos     (op9),
        .o_last    (ol9),
        .o_idx_err (oe9)
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    // Expected beats of the WIN=4 instance: {last, pos[1:0], data[15:0]}.
    logic [18:0] exp_q[$];

    typedef struct {
        int val;
        int idx;
        int exp[4];
    } vec_t;

    task automatic chk(input string nm, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_beat4(input string nm, input int d, input int p, input int l);
        chk({nm, "_valid"}, ov4, 1);
        chk({nm, "_data"},  od4, d);
        chk({nm, "_pos"},   op4, p);
        chk({nm, "_last"},  ol4, l);
    endtask

    task automatic chk_beat9(input string nm, input int d, input int p, input int l);
        chk({nm, "_valid"}, ov9, 1);
        chk({nm, "_data"},  od9, d);
        chk({nm, "_pos"},   op9, p);
        chk({nm, "_last"},  ol9, l);
        chk({nm, "_err"},   oe9, 1);
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        vec_t tbl[4];
        int   bb[8];
        logic exp_ready;
        logic [18:0] e;
        logic signed [15:0] dv;

        tbl[0].val = -5;      tbl[0].idx = 2; tbl[0].exp = '{0, 0, -5, 0};
        tbl[1].val = 7;       tbl[1].idx = 0; tbl[1].exp = '{7, 0, 0, 0};
        tbl[2].val = -32768;  tbl[2].idx = 3; tbl[2].exp = '{0, 0, 0, -32768};
        tbl[3].val = 32767;   tbl[3].idx = 1; tbl[3].exp = '{0, 32767, 0, 0};
        bb = '{7, 0, 0, 0, 0, 0, 0, -32768};

        // Reset held 3 cycles with a descriptor offered: nothing may start.
        rst4 = 1'b1; v4 = 1'b1; d4 = 16'sd123; idx4 = 2'd1; ir4 = 1'b1;
        rst9 = 1'b1; v9 = 1'b1; d9 = -16'sd7;  idx9 = 4'd2; ir9 = 1'b1;
        repeat (3) begin
            next();
            #1;
            chk("rst_valid", ov4, 0);
            chk("rst_data",  od4, 0);
            chk("rst_pos",   op4, 0);
            chk("rst_last",  ol4, 0);
            chk("rst_err",   oe4, 0);
            chk("rst_valid9", ov9, 0);
            chk("rst_err9",   oe9, 0);
        end
        next();
        rst4 = 1'b0; v4 = 1'b0; rst9 = 1'b0; v9 = 1'b0;
        #1;
        chk("post_rst_ready",  rdy4, 1);
        chk("post_rst_ready9", rdy9, 1);
        next();
        #1;
        chk("post_rst_novalid", ov4, 0);

        // Table vectors: one window each, i_ready held high.
        for (int i = 0; i < 4; i++) begin
            next();
            v4 = 1'b1; d4 = 16'(tbl[i].val); idx4 = 2'(tbl[i].idx); ir4 = 1'b1;
            #1;
            chk("tbl_ready", rdy4, 1);
            chk("tbl_pre_valid", ov4, 0);
            next();
            v4 = 1'b0;
            for (int b = 0; b < 4; b++) begin
                #1;
                chk_beat4($sformatf("tbl%0d_b%0d", i, b), tbl[i].exp[b], b, (b == 3) ? 1 : 0);
                next();
            end
            #1;
            chk("tbl_done_valid", ov4, 0);
        end

        // Back-to-back windows with no bubble.
        next();
        v4 = 1'b1; d4 = 16'sd7; idx4 = 2'd0; ir4 = 1'b1;
        #1;
        chk("b2b_ready0", rdy4, 1);
        next();
        d4 = -16'sd32768; idx4 = 2'd3;
        for (int b = 0; b < 8; b++) begin
            #1;
            chk_beat4($sformatf("b2b_b%0d", b), bb[b], b % 4, (b % 4 == 3) ? 1 : 0);
            if (b == 3) chk("b2b_ready_last", rdy4, 1);
            if (b < 3)  chk("b2b_ready_mid", rdy4, 0);
            next();
            if (b == 3) v4 = 1'b0;
        end
        #1;
        chk("b2b_done_valid", ov4, 0);

        // Backpressure for 3 cycles at slot 1.
        next();
        v4 = 1'b1; d4 = 16'sd9; idx4 = 2'd1; ir4 = 1'b1;
        next();
        v4 = 1'b0;
        #1;
        chk_beat4("bp_b0", 0, 0, 0);
        next();
        ir4 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk_beat4($sformatf("bp_hold%0d", k), 9, 1, 0);
            chk("bp_ready", rdy4, 0);
            next();
        end
        ir4 = 1'b1;
        #1;
        chk_beat4("bp_resume1", 9, 1, 0);
        next();
        #1;
        chk_beat4("bp_resume2", 0, 2, 0);
        next();
        #1;
        chk_beat4("bp_resume3", 0, 3, 1);
        next();
        #1;
        chk("bp_done_valid", ov4, 0);

        // Reset in the middle of a window.
        next();
        v4 = 1'b1; d4 = 16'sd11; idx4 = 2'd2; ir4 = 1'b1;
        next();
        v4 = 1'b0;
        #1; chk_beat4("mr_b0", 0, 0, 0);
        next();
        #1; chk_beat4("mr_b1", 0, 1, 0);
        next();
        #1; chk_beat4("mr_b2", 11, 2, 0);
        rst4 = 1'b1;
        next();
        rst4 = 1'b0;
        #1;
        chk("mr_valid", ov4, 0);
        chk("mr_ready", rdy4, 1);
        chk("mr_pos", op4, 0);
        v4 = 1'b1; d4 = 16'sd3; idx4 = 2'd1;
        next();
        v4 = 1'b0;
        for (int b = 0; b < 4; b++) begin
            #1;
            chk_beat4($sformatf("mr_new_b%0d", b), (b == 1) ? 3 : 0, b, (b == 3) ? 1 : 0);
            next();
        end
        #1;
        chk("mr_done_valid", ov4, 0);

        // Out-of-range index on the 9-slot instance, then a good window.
        next();
        v9 = 1'b1; d9 = 16'sd100; idx9 = 4'd12; ir9 = 1'b1;
        #1;
        chk("bad_ready", rdy9, 1);
        chk("bad_err_before", oe9, 0);
        next();
        v9 = 1'b0;
        for (int b = 0; b < 9; b++) begin
            #1;
            chk_beat9($sformatf("bad_b%0d", b), 0, b, (b == 8) ? 1 : 0);
            next();
        end
        v9 = 1'b1; d9 = 16'sd55; idx9 = 4'd4;
        #1;
        chk("good9_ready", rdy9, 1);
        next();
        v9 = 1'b0;
        for (int b = 0; b < 9; b++) begin
            #1;
            chk_beat9($sformatf("good9_b%0d", b), (b == 4) ? 55 : 0, b, (b == 8) ? 1 : 0);
            next();
        end
        #1;
        chk("good9_err_sticky", oe9, 1);
        chk("good9_done_valid", ov9, 0);
        rst9 = 1'b1;
        next();
        rst9 = 1'b0;
        #1;
        chk("err_cleared", oe9, 0);

        // Randomized traffic against a window-level model of the stream.
        for (int cyc = 0; cyc < 800; cyc++) begin
            next();
            if (cyc < 780) begin
                v4   = ($urandom_range(0, 9) < 6);
                d4   = 16'($urandom);
                idx4 = 2'($urandom_range(0, 3));
                ir4  = ($urandom_range(0, 9) < 7);
            end else begin
                v4  = 1'b0;
                ir4 = 1'b1;
            end
            #1;
            exp_ready = (exp_q.size() == 0) || ((exp_q.size() == 1) && ir4);
            chk("rnd_ready", rdy4, exp_ready);
            chk("rnd_valid", ov4, (exp_q.size() > 0) ? 1 : 0);
            if ((exp_q.size() > 0) && ir4) begin
                e = exp_q.pop_front();
                chk("rnd_data", od4, $signed(e[15:0]));
                chk("rnd_pos",  op4, e[17:16]);
                chk("rnd_last", ol4, e[18]);
            end
            if (v4 && exp_ready) begin
                for (int k = 0; k < 4; k++) begin
                    dv = (k == int'(idx4)) ? d4 : 16'sd0;
                    exp_q.push_back({(k == 3), 2'(k), dv});
                end
            end
        end
        chk("rnd_err_never", oe4, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
